// File: rtl/poly_arith_pkg.sv
// Shared arithmetic constants: coefficient width and err_o bit positions.
package poly_arith_pkg;

  localparam int COEFF_W = 12;

  localparam int ERR_W        = 3;
  localparam int ERR_ISSUE    = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_ALIGN    = 2;

endpackage

// File: rtl/delay_n.sv
// Fixed-length delay line, DEPTH register stages of DWIDTH bits.
module delay_n #(
  parameter int DWIDTH = 1,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] d_i,
  output logic [DWIDTH-1:0] q_o
);

  logic [DWIDTH-1:0] sr_q [DEPTH];
  logic [DWIDTH-1:0] sr_d [DEPTH];

  always_comb begin
    sr_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/pipe_drain_fifo.sv
// Credit-gated result FIFO behind a fixed-latency pipeline, with an issue
// shadow that flags results not matching an earlier issue.
module pipe_drain_fifo
  import poly_arith_pkg::*;
#(
  parameter int DWIDTH  = COEFF_W,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       issue_ready_o,
  input  logic                       issue_i,
  input  logic                       pipe_valid_i,
  input  logic [DWIDTH-1:0]          pipe_data_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [DWIDTH-1:0]          m_data_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [ERR_W-1:0]           err_o
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  cnt_q, cnt_d;
  logic [LVL_W-1:0]  infl_q, infl_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              rdy_en_q, rdy_en_d;

  logic [LVL_W:0] lvl_sum;
  logic           acc_issue;
  logic           pop;
  logic           full;
  logic           push;
  logic           drop;
  logic           infl_dec;
  logic           shadow_v;

  // Extra bit keeps the sum honest if a misbehaving pipeline overfills.
  assign lvl_sum       = {1'b0, cnt_q} + {1'b0, infl_q};
  assign issue_ready_o = rdy_en_q && (lvl_sum < (LVL_W+1)'(DEPTH));
  assign level_o       = (lvl_sum > (LVL_W+1)'(DEPTH)) ? LVL_W'(DEPTH) : lvl_sum[LVL_W-1:0];
  assign m_valid_o     = (cnt_q != '0);
  assign m_data_o      = mem_q[rd_ptr_q];
  assign err_o         = err_q;

  assign acc_issue = issue_i && issue_ready_o;
  assign pop       = m_valid_o && m_ready_i;
  assign full      = (cnt_q == LVL_W'(DEPTH));
  assign push      = pipe_valid_i && (!full || pop);
  assign drop      = pipe_valid_i && full && !pop;
  assign infl_dec  = pipe_valid_i && (infl_q != '0);

  delay_n #(
    .DWIDTH(1),
    .DEPTH (LATENCY)
  ) u_shadow (
    .clk (clk),
    .rst (rst),
    .d_i (acc_issue),
    .q_o (shadow_v)
  );

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    infl_d   = infl_q;
    err_d    = err_q;
    rdy_en_d = 1'b1;

    if (push) begin
      mem_d[wr_ptr_q] = pipe_data_i;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    if (push && !pop) begin
      cnt_d = cnt_q + LVL_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - LVL_W'(1);
    end

    // A result with nothing in flight is already an align error; don't underflow.
    if (acc_issue && !infl_dec) begin
      infl_d = infl_q + LVL_W'(1);
    end else if (infl_dec && !acc_issue) begin
      infl_d = infl_q - LVL_W'(1);
    end

    if (shadow_v != pipe_valid_i) err_d[ERR_ALIGN]    = 1'b1;
    if (drop)                     err_d[ERR_OVERFLOW] = 1'b1;
    if (issue_i && !issue_ready_o) err_d[ERR_ISSUE]   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      infl_q   <= '0;
      err_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      infl_q   <= infl_d;
      err_q    <= err_d;
      rdy_en_q <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// Directed bench for pipe_drain_fifo; the bench models the upstream pipeline.
module tb_pipe_drain_fifo;

  localparam int DW  = 12;
  localparam int LAT = 3;
  localparam int DEP = 8;
  localparam int LW  = $clog2(DEP + 1);

  logic          clk;
  logic          rst;
  logic          issue_ready_o;
  logic          issue_i;
  logic          pipe_valid_i;
  logic [DW-1:0] pipe_data_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_data_o;
  logic [LW-1:0] level_o;
  logic [2:0]    err_o;

  pipe_drain_fifo #(.DWIDTH(DW), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_ready_o(issue_ready_o),
    .issue_i      (issue_i),
    .pipe_valid_i (pipe_valid_i),
    .pipe_data_i  (pipe_data_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .level_o      (level_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // upstream pipeline model
  logic          pv_q [LAT];
  logic [DW-1:0] pd_q [LAT];

  // per-cycle samples, taken before the edge that consumes the inputs
  logic          s_ready, s_valid, s_acc, s_pv;
  logic [DW-1:0] s_data, s_pd;
  logic [LW-1:0] s_level;
  logic [2:0]    s_err;

  logic [DW-1:0] exp_q [$];

  task automatic clear_pipe();
    for (int i = 0; i < LAT; i++) begin
      pv_q[i] = 1'b0;
      pd_q[i] = '0;
    end
  endtask

  task automatic cyc(input logic iss, input logic [DW-1:0] d, input logic rdy,
                     input logic inj, input logic [DW-1:0] inj_d);
    logic          pv;
    logic [DW-1:0] pd;
    pv = pv_q[LAT-1] | inj;
    pd = inj ? inj_d : pd_q[LAT-1];
    issue_i      = iss;
    m_ready_i    = rdy;
    pipe_valid_i = pv;
    pipe_data_i  = pd;
    #1;
    s_ready = issue_ready_o;
    s_valid = m_valid_o;
    s_data  = m_data_o;
    s_level = level_o;
    s_err   = err_o;
    s_acc   = iss && issue_ready_o;
    s_pv    = pv;
    s_pd    = pd;
    @(posedge clk);
    for (int i = LAT-1; i > 0; i--) begin
      pv_q[i] = pv_q[i-1];
      pd_q[i] = pd_q[i-1];
    end
    pv_q[0] = s_acc;
    pd_q[0] = d;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst          = 1'b0;
    issue_i      = 1'b0;
    pipe_valid_i = 1'b0;
    pipe_data_i  = '0;
    m_ready_i    = 1'b0;
    clear_pipe();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc(0, '0, 0, 0, '0);
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    issue_i      = 1'b0;
    pipe_valid_i = 1'b0;
    pipe_data_i  = '0;
    m_ready_i    = 1'b0;
    clear_pipe();
    #12;
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", issue_ready_o); end
    total++; if (m_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", m_valid_o); end
    total++; if (m_data_o !== '0) begin bad++; $display("FAIL rst_data got=%h want=000", m_data_o); end
    total++; if (level_o !== '0) begin bad++; $display("FAIL rst_level got=%0d want=0", level_o); end
    total++; if (err_o !== 3'b000) begin bad++; $display("FAIL rst_err got=%b want=000", err_o); end
    @(negedge clk);
    rst = 1'b1;
    cyc(0, '0, 0, 0, '0);
    cyc(0, '0, 0, 0, '0);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL first_edge_ready got=%b want=1", s_ready); end
    for (int k = 0; k < 10; k++) cyc(0, '0, 0, 0, '0);
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", s_ready); end
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", s_valid); end
    total++; if (s_level !== '0) begin bad++; $display("FAIL idle_level got=%0d want=0", s_level); end
    total++; if (s_err !== 3'b000) begin bad++; $display("FAIL idle_err got=%b want=000", s_err); end
  endtask

  task automatic test_single();
    logic          v [7];
    logic [DW-1:0] dt [7];
    logic [LW-1:0] lv [7];
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      cyc(k == 0, 12'h123, 1, 0, '0);
      v[k] = s_valid; dt[k] = s_data; lv[k] = s_level;
    end
    total++; if (lv[1] !== LW'(1)) begin bad++; $display("FAIL single_level_c1 got=%0d want=1", lv[1]); end
    total++; if (v[3] !== 1'b0) begin bad++; $display("FAIL single_valid_c3 got=%b want=0", v[3]); end
    total++; if (v[4] !== 1'b1) begin bad++; $display("FAIL single_valid_c4 got=%b want=1", v[4]); end
    total++; if (dt[4] !== 12'h123) begin bad++; $display("FAIL single_data_c4 got=%h want=123", dt[4]); end
    total++; if (lv[4] !== LW'(1)) begin bad++; $display("FAIL single_level_c4 got=%0d want=1", lv[4]); end
    total++; if (lv[5] !== '0) begin bad++; $display("FAIL single_level_c5 got=%0d want=0", lv[5]); end
    total++; if (v[5] !== 1'b0) begin bad++; $display("FAIL single_valid_c5 got=%b want=0", v[5]); end
    total++; if (s_err !== 3'b000) begin bad++; $display("FAIL single_err got=%b want=000", s_err); end
  endtask

  task automatic test_fill();
    int acc;
    acc = 0;
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      cyc(issue_ready_o, DW'(12'h100 + acc), 0, 0, '0);
      if (s_acc) acc++;
    end
    total++; if (acc != DEP) begin bad++; $display("FAIL fill_accepted got=%0d want=%0d", acc, DEP); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b want=0", s_ready); end
    total++; if (s_level !== LW'(DEP)) begin bad++; $display("FAIL fill_level got=%0d want=%0d", s_level, DEP); end
    for (int j = 0; j < DEP; j++) begin
      cyc(0, '0, 1, 0, '0);
      total++; if (s_valid !== 1'b1 || s_data !== DW'(12'h100 + j)) begin
        bad++; $display("FAIL drain_%0d got=%b/%h want=1/%h", j, s_valid, s_data, DW'(12'h100 + j));
      end
    end
    cyc(0, '0, 1, 0, '0);
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", s_valid); end
    total++; if (s_err !== 3'b000) begin bad++; $display("FAIL fill_err got=%b want=000", s_err); end
  endtask

  task automatic test_back_to_back();
    int acc, pops, sb_bad;
    logic [DW-1:0] e;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      cyc(issue_ready_o, DW'($urandom_range(0, 4095)), 0, 0, '0);
      if (s_pv) exp_q.push_back(s_pd);
    end
    total++; if (s_level !== LW'(DEP) || exp_q.size() != DEP) begin
      bad++; $display("FAIL b2b_prefill got=%0d/%0d want=%0d", s_level, exp_q.size(), DEP);
    end
    acc = 0; pops = 0; sb_bad = 0;
    for (int k = 0; k < 200; k++) begin
      cyc(issue_ready_o, DW'($urandom_range(0, 4095)), 1, 0, '0);
      if (s_acc) acc++;
      if (s_valid) begin
        pops++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_spurious cycle=%0d got=%h want=none", k, s_data);
        end else begin
          e = exp_q.pop_front();
          if (s_data !== e) begin
            bad++; sb_bad++;
            if (sb_bad < 5) $display("FAIL b2b_order cycle=%0d got=%h want=%h", k, s_data, e);
          end
        end
      end
      if (s_pv) exp_q.push_back(s_pd);
    end
    total++; if (pops != 200) begin bad++; $display("FAIL b2b_throughput got=%0d want=200", pops); end
    total++; if (acc != 199) begin bad++; $display("FAIL b2b_issues got=%0d want=199", acc); end
    for (int k = 0; k < 12; k++) begin
      cyc(0, '0, 1, 0, '0);
      if (s_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++; if (s_data !== e) begin bad++; $display("FAIL b2b_tail got=%h want=%h", s_data, e); end
      end
      if (s_pv) exp_q.push_back(s_pd);
    end
    total++; if (exp_q.size() != 0 || s_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_leftover got=%0d/%b want=0/0", exp_q.size(), s_valid);
    end
    total++; if (s_err !== 3'b000) begin bad++; $display("FAIL b2b_err got=%b want=000", s_err); end
  endtask

  task automatic test_errors();
    apply_reset();
    cyc(0, '0, 0, 1, 12'h0AA);
    cyc(0, '0, 0, 0, '0);
    total++; if (s_err !== 3'b100) begin bad++; $display("FAIL err_align got=%b want=100", s_err); end
    for (int k = 0; k < 12; k++) cyc(1, 12'h200, 0, 0, '0);
    for (int k = 0; k < 4; k++) cyc(0, '0, 0, 0, '0);
    total++; if (s_err !== 3'b101) begin bad++; $display("FAIL err_issue got=%b want=101", s_err); end
    total++; if (s_level !== LW'(DEP)) begin bad++; $display("FAIL err_level got=%0d want=%0d", s_level, DEP); end
    cyc(0, '0, 0, 1, 12'h3FF);
    cyc(0, '0, 0, 0, '0);
    total++; if (s_err !== 3'b111) begin bad++; $display("FAIL err_overflow got=%b want=111", s_err); end
    total++; if (s_level !== LW'(DEP)) begin bad++; $display("FAIL drop_level got=%0d want=%0d", s_level, DEP); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 0; k < 8; k++) cyc(k < 7, DW'(12'h300 + k), 0, 0, '0);
    total++; if (level_o !== LW'(7) || m_valid_o !== 1'b1) begin
      bad++; $display("FAIL mid_before got=%0d/%b want=7/1", level_o, m_valid_o);
    end
    #2 rst = 1'b0;
    #1;
    total++; if ({issue_ready_o, m_valid_o, m_data_o, level_o, err_o} !== '0) begin
      bad++; $display("FAIL mid_reset got=%b/%b/%h/%0d/%b want=0", issue_ready_o, m_valid_o, m_data_o, level_o, err_o);
    end
    #1 rst = 1'b1;
    cyc(0, '0, 0, 0, '0);
    cyc(0, '0, 0, 0, '0);
    total++; if (s_err !== 3'b100) begin bad++; $display("FAIL mid_late_align got=%b want=100", s_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
